// File: rtl/cpu_oci_dct_packer.sv
// rtl/cpu_oci_dct_packer.sv - packs 2-bit DCT trace codes into 15-slot, 30-bit trace words
module cpu_oci_dct_packer #(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [1:0]        code,
    input  logic              flush,
    input  logic              overflow_clr,
    output logic [29:0]       dct_buffer,
    output logic [3:0]        dct_count,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [29:0]       frame_buffer,
    output logic [3:0]        frame_count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    logic [29:0]       r_acc_buf;
    logic [3:0]        r_acc_cnt;
    logic              r_frame_valid;
    logic [29:0]       r_frame_buf;
    logic [3:0]        r_frame_cnt;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_flush_pend;

    logic              w_accept;
    logic              w_out_free;
    logic              w_full;
    logic              w_flush_any;
    logic [3:0]        w_cnt_next;
    logic [29:0]       w_buf_next;
    logic [29:0]       w_code_shifted;
    logic              w_transfer;
    logic              w_drop;

    assign w_accept       = code_valid && (code != 2'b00);
    assign w_out_free     = !r_frame_valid || frame_ready;
    assign w_full         = (r_acc_cnt == 4'd15);
    assign w_flush_any    = flush || r_flush_pend;
    assign w_code_shifted = {28'd0, code} << {r_acc_cnt, 1'b0};
    // Next-state accumulator view; only meaningful while the accumulator is not full.
    assign w_cnt_next     = r_acc_cnt + {3'd0, w_accept};
    assign w_buf_next     = w_accept ? (r_acc_buf | w_code_shifted) : r_acc_buf;
    assign w_transfer     = w_out_free &&
                            (w_full || (w_cnt_next == 4'd15) ||
                             (w_flush_any && (w_cnt_next != 4'd0)));
    assign w_drop         = w_full && !w_out_free && w_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_buf     <= '0;
            r_acc_cnt     <= '0;
            r_frame_valid <= 1'b0;
            r_frame_buf   <= '0;
            r_frame_cnt   <= '0;
            r_flush_pend  <= 1'b0;
        end else if (w_transfer) begin
            r_frame_valid <= 1'b1;
            r_frame_buf   <= w_full ? r_acc_buf : w_buf_next;
            r_frame_cnt   <= w_full ? 4'd15 : w_cnt_next;
            // A code arriving while a full word leaves starts the next word in slot 0.
            if (w_full && w_accept) begin
                r_acc_buf    <= {28'd0, code};
                r_acc_cnt    <= 4'd1;
                r_flush_pend <= flush;
            end else begin
                r_acc_buf    <= '0;
                r_acc_cnt    <= '0;
                r_flush_pend <= 1'b0;
            end
        end else begin
            if (frame_ready) begin
                r_frame_valid <= 1'b0;
            end
            if (!w_full) begin
                r_acc_buf <= w_buf_next;
                r_acc_cnt <= w_cnt_next;
            end
            r_flush_pend <= w_flush_any && (w_full || (w_cnt_next != 4'd0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (overflow_clr) begin
                r_drop_cnt <= DROP_W'(1);
            end else if (!(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign dct_buffer   = r_acc_buf;
    assign dct_count    = r_acc_cnt;
    assign frame_valid  = r_frame_valid;
    assign frame_buffer = r_frame_buf;
    assign frame_count  = r_frame_cnt;
    assign overflow     = r_overflow;
    assign drop_count   = r_drop_cnt;

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// tb/tb_cpu_oci_dct_packer.sv - vector table plus frame scoreboard for cpu_oci_dct_packer
module tb_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        code_valid = 1'b0;
    logic [1:0]  code = 2'b00;
    logic        flush = 1'b0;
    logic        overflow_clr = 1'b0;
    logic        frame_ready = 1'b1;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic [29:0] frame_buffer;
    logic [3:0]  frame_count;
    logic        overflow;
    logic [7:0]  drop_count;

    cpu_oci_dct_packer #(.DROP_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .code_valid   (code_valid),
        .code         (code),
        .flush        (flush),
        .overflow_clr (overflow_clr),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_buffer (frame_buffer),
        .frame_count  (frame_count),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cnt;
        logic [29:0] buff;
    } frame_t;

    typedef struct {
        int          n;
        logic [29:0] codes;
        bit          do_flush;
        logic [3:0]  exp_cnt;
        logic [29:0] exp_buf;
    } vec_t;

    frame_t     sb[$];
    vec_t       vecs[5];
    int         n_checks = 0;
    int         n_fail = 0;
    int         valid_cycles = 0;
    bit         prev_hold = 1'b0;
    logic [29:0] prev_buf;
    logic [3:0]  prev_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        frame_t f;
        if (!reset) begin
            if (prev_hold) begin
                check("hold_buf", {2'b0, frame_buffer}, {2'b0, prev_buf});
                check("hold_cnt", {28'd0, frame_count}, {28'd0, prev_cnt});
            end
            if (frame_valid) valid_cycles++;
            if (frame_valid && frame_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", {28'd0, frame_count}, 32'd0);
                end else begin
                    f = sb.pop_front();
                    check("frame_cnt", {28'd0, frame_count}, {28'd0, f.cnt});
                    check("frame_buf", {2'b0, frame_buffer}, {2'b0, f.buff});
                end
            end
        end
        prev_hold = !reset && frame_valid && !frame_ready;
        prev_buf  = frame_buffer;
        prev_cnt  = frame_count;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        code_valid = 1'b1;
        code = c;
        step();
        code_valid = 1'b0;
        code = 2'b00;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic push(input logic [3:0] c, input logic [29:0] b);
        frame_t f;
        f.cnt = c;
        f.buff = b;
        sb.push_back(f);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            step();
            k++;
        end
        step();
        check(name, sb.size(), 32'd0);
    endtask

    initial begin
        logic [29:0] w;
        vecs[0] = '{15, 30'h26666666, 1'b0, 4'd15, 30'h26666666};
        vecs[1] = '{3,  30'h00000027, 1'b1, 4'd3,  30'h00000027};
        vecs[2] = '{1,  30'h00000003, 1'b1, 4'd1,  30'h00000003};
        vecs[3] = '{15, 30'h3FFFFFFF, 1'b0, 4'd15, 30'h3FFFFFFF};
        vecs[4] = '{7,  30'h00001555, 1'b1, 4'd7,  30'h00001555};

        step();
        step();
        check("rst_dct_buffer", {2'b0, dct_buffer}, 32'd0);
        check("rst_dct_count", {28'd0, dct_count}, 32'd0);
        check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_frame_buffer", {2'b0, frame_buffer}, 32'd0);
        check("rst_frame_count", {28'd0, frame_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_drop_count", {24'd0, drop_count}, 32'd0);
        reset = 1'b0;
        step();

        for (int v = 0; v < 5; v++) begin
            valid_cycles = 0;
            push(vecs[v].exp_cnt, vecs[v].exp_buf);
            w = vecs[v].codes;
            for (int i = 0; i < vecs[v].n; i++) begin
                send(w[1:0]);
                w = w >> 2;
            end
            if (vecs[v].do_flush) do_flush();
            drain("vec_drain");
            check("vec_valid_cycles", valid_cycles, 32'd1);
            check("vec_dct_count", {28'd0, dct_count}, 32'd0);
        end

        valid_cycles = 0;
        do_flush();
        repeat (5) step();
        check("empty_flush_no_frame", valid_cycles, 32'd0);

        frame_ready = 1'b0;
        push(4'd15, 30'h2AAAAAAA);
        push(4'd15, 30'h2AAAAAAA);
        for (int i = 0; i < 31; i++) send(2'b10);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_drop", {24'd0, drop_count}, 32'd1);
        check("ovf_dct_count", {28'd0, dct_count}, 32'd15);
        check("ovf_frame_valid", {31'd0, frame_valid}, 32'd1);
        valid_cycles = 0;
        frame_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_two_frames", valid_cycles, 32'd2);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("clr_overflow", {31'd0, overflow}, 32'd0);
        check("clr_drop", {24'd0, drop_count}, 32'd0);

        frame_ready = 1'b0;
        push(4'd15, 30'h15555555);
        push(4'd15, 30'h15555555);
        push(4'd1, 30'h00000003);
        for (int i = 0; i < 30; i++) send(2'b01);
        frame_ready = 1'b1;
        send(2'b11);
        check("full_ready_dct_count", {28'd0, dct_count}, 32'd1);
        check("full_ready_dct_buffer", {2'b0, dct_buffer}, 32'd3);
        check("full_ready_no_drop", {24'd0, drop_count}, 32'd0);
        do_flush();
        drain("full_ready_drain");

        push(4'd5, 30'h00000279);
        send(2'b01); send(2'b00); send(2'b10); send(2'b00);
        send(2'b11); send(2'b00); send(2'b01); send(2'b00);
        send(2'b10);
        do_flush();
        drain("zero_code_drain");
        check("zero_code_drop", {24'd0, drop_count}, 32'd0);

        frame_ready = 1'b0;
        for (int i = 0; i < 22; i++) send(2'b11);
        flush = 1'b1;
        reset = 1'b1;
        step();
        flush = 1'b0;
        check("mid_rst_dct_count", {28'd0, dct_count}, 32'd0);
        check("mid_rst_dct_buffer", {2'b0, dct_buffer}, 32'd0);
        check("mid_rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        check("mid_rst_frame_buffer", {2'b0, frame_buffer}, 32'd0);
        check("mid_rst_frame_count", {28'd0, frame_count}, 32'd0);
        reset = 1'b0;
        frame_ready = 1'b1;
        valid_cycles = 0;
        send(2'b10);
        repeat (4) step();
        check("rst_clears_flush_pend", valid_cycles, 32'd0);
        check("post_rst_dct_count", {28'd0, dct_count}, 32'd1);
        push(4'd1, 30'h00000002);
        do_flush();
        drain("post_rst_drain");

        frame_ready = 1'b0;
        push(4'd15, 30'h2AAAAAAA);
        push(4'd15, 30'h2AAAAAAA);
        for (int i = 0; i < 31; i++) send(2'b10);
        overflow_clr = 1'b1;
        send(2'b10);
        overflow_clr = 1'b0;
        check("clr_with_drop_flag", {31'd0, overflow}, 32'd1);
        check("clr_with_drop_count", {24'd0, drop_count}, 32'd1);
        frame_ready = 1'b1;
        drain("clr_drop_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
